// File: rtl/snapshot_mem_bridge.sv
// Bridge from the reg_native bus to a memory word wider than the bus, with a one-word snapshot buffer.
// The SNAPSHOT_MEM_TIMEOUT_EN macro adds a memory-ack timeout that answers with err after TIMEOUT_CYCLES.
module snapshot_mem_bridge #(
  parameter int BUS_DATA_WIDTH = 32,
  parameter int BUS_ADDR_WIDTH = 64,
  parameter int MEM_DATA_WIDTH = 128,
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      soft_rst,
  input  logic                      req_vld,
  input  logic [BUS_ADDR_WIDTH-1:0] addr,
  input  logic                      wr_en,
  input  logic                      rd_en,
  input  logic [BUS_DATA_WIDTH-1:0] wr_data,
  output logic                      ack_vld,
  output logic [BUS_DATA_WIDTH-1:0] rd_data,
  output logic                      err,
  output logic                      snap_dirty,
  output logic                      mem_req_vld,
  input  logic                      mem_ack_vld,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic                      mem_wr_en,
  output logic                      mem_rd_en,
  output logic [MEM_DATA_WIDTH-1:0] mem_wr_data,
  input  logic [MEM_DATA_WIDTH-1:0] mem_rd_data,
  output logic [1:0]                dbg_state
);

  localparam int N    = MEM_DATA_WIDTH / BUS_DATA_WIDTH;
  localparam int OFS  = $clog2(MEM_DATA_WIDTH / 8);
  localparam int BOFS = $clog2(BUS_DATA_WIDTH / 8);
  localparam int IW   = (N > 1) ? $clog2(N) : 1;

  if ((MEM_DATA_WIDTH % BUS_DATA_WIDTH) != 0 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("snapshot_mem_bridge: illegal parameter combination");
  end

  // Handshake: req_vld is a one-cycle strobe taken only in IDLE and answered by exactly one
  // ack_vld pulse; mem_req_vld holds with stable address/qualifiers through the mem_ack_vld cycle.
  typedef enum logic [1:0] {IDLE, MEM, SNAP, RESP} state_t;
  state_t state, state_nxt;

  logic [MEM_DATA_WIDTH-1:0] buf_q;
  logic [BUS_DATA_WIDTH-1:0] wr_data_q;
  logic [IW-1:0]             idx_q;
  logic [IW-1:0]             req_idx;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q;
  logic                      wr_q, rd_q, err_q, dirty_q;
  logic                      req_bad, mem_timeout;
  logic                      unused_addr;

  assign req_idx     = IW'(addr[OFS-1:0] >> BOFS);
  assign req_bad     = (wr_en == rd_en);
  assign unused_addr = ^addr;

`ifdef SNAPSHOT_MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         to_cnt <= '0;
    else if (soft_rst || state != MEM || mem_ack_vld)   to_cnt <= '0;
    else                                                to_cnt <= to_cnt + 1'b1;
  end

  // An ack arriving in the expiry cycle takes precedence over the timeout.
  assign mem_timeout = (state == MEM) && !mem_ack_vld && (to_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign mem_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        state <= IDLE;
    else if (soft_rst) state <= IDLE;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_vld) begin
              if (req_bad)              state_nxt = RESP;
              else if (req_idx == '0)   state_nxt = MEM;
              else                      state_nxt = SNAP;
            end
      MEM:  if (mem_ack_vld || mem_timeout) state_nxt = RESP;
      SNAP: state_nxt = IDLE;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '0; wr_data_q <= '0; idx_q <= '0; mem_addr_q <= '0;
      wr_q <= 1'b0; rd_q <= 1'b0; err_q <= 1'b0; dirty_q <= 1'b0;
    end else if (soft_rst) begin
      buf_q <= '0; wr_data_q <= '0; idx_q <= '0; mem_addr_q <= '0;
      wr_q <= 1'b0; rd_q <= 1'b0; err_q <= 1'b0; dirty_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_vld) begin
                wr_q      <= wr_en;
                rd_q      <= rd_en;
                err_q     <= req_bad;
                idx_q     <= req_idx;
                wr_data_q <= wr_data;
                if (!req_bad && req_idx == '0)
                  mem_addr_q <= addr[OFS+MEM_ADDR_WIDTH-1:OFS];
              end
        SNAP: if (wr_q) begin
                buf_q[int'(idx_q)*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] <= wr_data_q;
                dirty_q <= 1'b1;
              end
        MEM:  if (mem_ack_vld) begin
                if (wr_q) buf_q[BUS_DATA_WIDTH-1:0] <= wr_data_q;
                else      buf_q <= mem_rd_data;
                dirty_q <= 1'b0;
              end else if (mem_timeout) begin
                err_q <= 1'b1;
              end
        default: ;
      endcase
    end
  end

  always_comb begin
    ack_vld = (state == SNAP) || (state == RESP);
    err     = ack_vld && err_q;
    rd_data = '0;
    if (state == SNAP && rd_q)
      rd_data = buf_q[int'(idx_q)*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
    else if (state == RESP && rd_q && !err_q)
      rd_data = buf_q[BUS_DATA_WIDTH-1:0];
  end

  assign mem_req_vld = (state == MEM);
  assign mem_wr_en   = (state == MEM) && wr_q;
  assign mem_rd_en   = (state == MEM) && rd_q;
  assign mem_addr    = mem_addr_q;
  assign snap_dirty  = dirty_q;
  assign dbg_state   = state;

  // Partition 0 always comes from the bus; upper partitions from the snapshot.
  if (N == 1) begin : g_pass
    assign mem_wr_data = wr_data_q;
  end else begin : g_snap
    assign mem_wr_data = {buf_q[MEM_DATA_WIDTH-1:BUS_DATA_WIDTH], wr_data_q};
  end

endmodule

// File: tb/tb_snapshot_mem_bridge.sv
// Directed bench for snapshot_mem_bridge (BUS 32, MEM 128, N=4) with a lane-level model and expected-ack queue.
// Build with SNAPSHOT_MEM_TIMEOUT_EN defined to exercise the timeout path (TIMEOUT_CYCLES=8).
module tb_snapshot_mem_bridge;

  logic         clk = 1'b0, rst_n = 1'b0, soft_rst = 1'b0;
  logic         req_vld = 1'b0, wr_en = 1'b0, rd_en = 1'b0, mem_ack_vld = 1'b0;
  logic [63:0]  addr = '0;
  logic [31:0]  wr_data = '0;
  logic [127:0] mem_rd_data = '0;
  logic         ack_vld, err, snap_dirty, mem_req_vld, mem_wr_en, mem_rd_en;
  logic [31:0]  rd_data, mem_addr;
  logic [127:0] mem_wr_data;
  logic [1:0]   dbg_state;

  int checks = 0, errors = 0, cyc = 0;
  logic [31:0]  m_buf [4];
  logic         m_dirty = 1'b0;
  logic         mem_expected = 1'b0;
  bit           checking = 1'b0;
  logic [64:0]  exp_q [$];
  logic [64:0]  e;
  logic [31:0]  last_rd = '0;
  logic         last_err = 1'b0;
  logic [127:0] last_mem_wr_data = '0;
  logic [31:0]  last_mem_addr = '0;

  snapshot_mem_bridge #(
    .BUS_DATA_WIDTH(32), .BUS_ADDR_WIDTH(64), .MEM_DATA_WIDTH(128),
    .MEM_ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .soft_rst(soft_rst), .req_vld(req_vld), .addr(addr),
    .wr_en(wr_en), .rd_en(rd_en), .wr_data(wr_data), .ack_vld(ack_vld), .rd_data(rd_data),
    .err(err), .snap_dirty(snap_dirty), .mem_req_vld(mem_req_vld), .mem_ack_vld(mem_ack_vld),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req_v, cyc);
    end
  endtask

  // compare process: every cycle, half a period after the active edge
  always @(negedge clk) begin
    #1;
    if (checking) begin
      check("mem_req_vld", mem_req_vld, mem_expected);
      if (ack_vld) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", ack_vld, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("ack_cycle", cyc, e[64:33]);
          check("ack_err", err, e[32]);
          check("ack_rd_data", rd_data, e[31:0]);
          last_rd  = rd_data;
          last_err = err;
        end
      end else begin
        check("idle_rd_data", rd_data, 32'h0);
        check("idle_err", err, 1'b0);
        if (exp_q.size() != 0 && cyc > int'(exp_q[0][64:33])) begin
          check("ack_missing", ack_vld, 1'b1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic wait_done();
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
  endtask

  // driver: one bus access; for partition-0 accesses also plays the memory
  task automatic access(input logic w, input logic r, input logic [63:0] a, input logic [31:0] d,
                        input int delay, input logic [127:0] mrd, input bit poke);
    int idx;
    int rc;
    idx = int'(a[3:2]);
    @(negedge clk);
    req_vld = 1'b1; wr_en = w; rd_en = r; addr = a; wr_data = d; rc = cyc;
    if (w == r) begin
      exp_q.push_back({32'(rc + 1), 1'b1, 32'h0});
    end else if (idx != 0) begin
      if (w) begin
        m_buf[idx] = d; m_dirty = 1'b1;
        exp_q.push_back({32'(rc + 1), 1'b0, 32'h0});
      end else begin
        exp_q.push_back({32'(rc + 1), 1'b0, m_buf[idx]});
      end
    end
    @(negedge clk);
    req_vld = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wr_data = '0;
    if (w != r && idx == 0) begin
      mem_expected = 1'b1;
      last_mem_addr = mem_addr;
      last_mem_wr_data = mem_wr_data;
      check("mem_addr", mem_addr, a[35:4]);
      check("mem_wr_en", mem_wr_en, w);
      check("mem_rd_en", mem_rd_en, r);
      if (w) check("mem_wr_data", mem_wr_data, {m_buf[3], m_buf[2], m_buf[1], d});
`ifdef SNAPSHOT_MEM_TIMEOUT_EN
      if (delay >= 8) begin
        exp_q.push_back({32'(rc + 9), 1'b1, 32'h0});
        repeat (8) @(negedge clk);
        mem_expected = 1'b0;
      end else
`endif
      begin
        for (int i = 0; i < delay; i++) begin
          if (poke && i == 0) begin
            req_vld = 1'b1; wr_en = 1'b1; addr = 64'h8; wr_data = 32'h99;
          end
          @(negedge clk);
          req_vld = 1'b0; wr_en = 1'b0; addr = '0; wr_data = '0;
        end
        mem_rd_data = mrd; mem_ack_vld = 1'b1;
        exp_q.push_back({32'(cyc + 1), 1'b0, w ? 32'h0 : mrd[31:0]});
        if (w) m_buf[0] = d;
        else for (int k = 0; k < 4; k++) m_buf[k] = mrd[k*32 +: 32];
        m_dirty = 1'b0;
        @(negedge clk);
        mem_ack_vld = 1'b0; mem_rd_data = '0; mem_expected = 1'b0;
      end
    end
    wait_done();
  endtask

  task automatic soft_reset_mid_mem(input logic [63:0] a);
    @(negedge clk);
    req_vld = 1'b1; rd_en = 1'b1; addr = a;
    @(negedge clk);
    req_vld = 1'b0; rd_en = 1'b0; addr = '0; mem_expected = 1'b1;
    repeat (4) @(negedge clk);
    soft_rst = 1'b1;
    @(negedge clk);
    soft_rst = 1'b0; mem_expected = 1'b0;
    for (int k = 0; k < 4; k++) m_buf[k] = '0;
    m_dirty = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) m_buf[k] = '0;
    repeat (3) @(negedge clk);
    check("rst_ack_vld", ack_vld, 1'b0);
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_err", err, 1'b0);
    check("rst_snap_dirty", snap_dirty, 1'b0);
    check("rst_mem_req_vld", mem_req_vld, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wr_data", mem_wr_data, 128'h0);
    check("rst_state", dbg_state, 2'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checking = 1'b1;

    // partial writes stay in the snapshot
    access(1, 0, 64'h4, 32'h11, 0, '0, 0);
    access(1, 0, 64'h8, 32'h22, 0, '0, 0);
    access(1, 0, 64'hC, 32'h33, 0, '0, 0);
    check("dirty_after_partials", snap_dirty, 1'b1);

    // partition-0 write commits the whole word
    access(1, 0, 64'h0, 32'hAA, 2, '0, 0);
    check("commit_wr_data", last_mem_wr_data, 128'h00000033_00000022_00000011_000000AA);
    check("dirty_after_commit", snap_dirty, 1'b0);

    // partition-0 read loads the buffer; upper lanes served locally
    access(0, 1, 64'h10, '0, 1, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 0);
    check("read_mem_addr", last_mem_addr, 32'h1);
    check("read_lane0", last_rd, 32'hAAAAAAAA);
    access(0, 1, 64'h14, '0, 0, '0, 0);
    access(0, 1, 64'h18, '0, 0, '0, 0);
    access(0, 1, 64'h1C, '0, 0, '0, 0);
    check("read_lane3", last_rd, 32'hDDDDDDDD);

    // illegal qualifiers
    access(1, 1, 64'h14, 32'h5A, 0, '0, 0);
    check("err_both", last_err, 1'b1);
    access(0, 0, 64'h0, 32'h5A, 0, '0, 0);
    access(0, 1, 64'h14, '0, 0, '0, 0);
    check("buf_after_err", last_rd, 32'hBBBBBBBB);

    // dirty lane then a memory access that stalls (or times out)
    access(1, 0, 64'h18, 32'h55, 0, '0, 0);
`ifdef SNAPSHOT_MEM_TIMEOUT_EN
    access(0, 1, 64'h30, '0, 8, '0, 0);
    check("timeout_err", last_err, 1'b1);
    check("timeout_dirty_kept", snap_dirty, 1'b1);
    access(0, 1, 64'h18, '0, 0, '0, 0);
    check("timeout_buf_kept", last_rd, 32'h55);
`else
    access(0, 1, 64'h30, '0, 20, 128'h44444444_33333333_22222222_11111111, 0);
    check("long_stall_rd", last_rd, 32'h11111111);
    check("long_stall_dirty", snap_dirty, 1'b0);
`endif

    // request during MEM is ignored
    access(0, 1, 64'h40, '0, 3, 128'h0C0C0C0C_0B0B0B0B_0A0A0A0A_09090909, 1);
    access(0, 1, 64'h48, '0, 0, '0, 0);
    check("poke_ignored", last_rd, 32'h0B0B0B0B);

    // stray memory ack while idle
    @(negedge clk); mem_ack_vld = 1'b1; mem_rd_data = '1;
    @(negedge clk); mem_ack_vld = 1'b0; mem_rd_data = '0;
    repeat (2) @(negedge clk);
    access(0, 1, 64'h44, '0, 0, '0, 0);
    check("stray_ack_ignored", last_rd, 32'h0A0A0A0A);

    // soft reset mid memory access
    soft_reset_mid_mem(64'h50);
    check("soft_rst_state", dbg_state, 2'd0);
    check("soft_rst_dirty", snap_dirty, 1'b0);
    access(0, 1, 64'h24, '0, 0, '0, 0);
    access(1, 0, 64'h4, 32'h77, 0, '0, 0);
    access(0, 1, 64'h4, '0, 0, '0, 0);
    check("after_soft_rst_rd", last_rd, 32'h77);
    access(1, 0, 64'h0, 32'hEE, 0, '0, 0);
    check("after_soft_rst_commit", last_mem_wr_data, 128'h00000000_00000000_00000077_000000EE);

    for (int i = 1; i < 4; i++) access(0, 1, 64'h100 + 64'(i * 4), '0, 0, '0, 0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
